// File: rtl/heaa_32b9inacc_sub_pipe_if.sv
// Operand/result stream bundle for the HEAA approximate subtractor.
// master drives operands and consumes results; slave is the datapath.
interface heaa_32b9inacc_sub_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   diff;

  modport master (
    output in_valid,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  diff
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output diff
  );
endinterface

// File: rtl/heaa_32b9inacc_sub_pipe.sv
// HEAA approximate subtractor a + ~b: OR low bits, half-add boundary,
// 4-bit-group CLA high part, two register stages on a valid/ready stream.
module heaa_32b9inacc_sub_pipe #(
  parameter int WIDTH = 32,
  parameter int INACC = 9
) (
  input logic clk,
  input logic rst_n,
  heaa_32b9inacc_sub_pipe_if.slave bus
);

  localparam int HW = WIDTH - INACC;
  localparam int NG = (HW + 3) / 4;
  localparam int PW = NG * 4;

  typedef struct packed {
    logic [INACC-1:0] lo;
    logic [HW-1:0]    p;
    logic [HW-1:0]    g;
    logic [NG-1:0]    gp;
    logic [NG-1:0]    gg;
    logic             c;
  } s1_t;

  s1_t            s1_d;
  s1_t            s1_q;
  logic           s1_valid;
  logic           s2_valid;
  logic [WIDTH:0] s2_d;
  logic [WIDTH:0] s2_q;
  logic           s1_adv;
  logic           s2_adv;

  logic [WIDTH-1:0] nb;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    gq;
  logic             pk;
  logic             gk;

  logic [NG:0]   cg;
  logic [HW-1:0] hs;
  logic          cr;

  assign s2_adv       = !s2_valid | bus.out_ready;
  assign s1_adv       = !s1_valid | s2_adv;
  assign bus.in_ready = s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.diff     = s2_q;

  always_comb begin
    nb   = ~bus.b;
    s1_d = '0;
    for (int i = 0; i < INACC - 1; i++) begin
      s1_d.lo[i] = bus.a[i] | nb[i];
    end
    s1_d.lo[INACC-1] = bus.a[INACC-1] ^ nb[INACC-1];
    s1_d.c = bus.a[INACC-1] & nb[INACC-1];
    s1_d.p = bus.a[WIDTH-1:INACC] ^ nb[WIDTH-1:INACC];
    s1_d.g = bus.a[WIDTH-1:INACC] & nb[WIDTH-1:INACC];
    // padding bits propagate and never generate, so a partial group is exact
    pp = '1;
    gq = '0;
    pp[HW-1:0] = s1_d.p;
    gq[HW-1:0] = s1_d.g;
    pk = 1'b1;
    gk = 1'b0;
    for (int k = 0; k < NG; k++) begin
      pk = 1'b1;
      gk = 1'b0;
      for (int j = 0; j < 4; j++) begin
        gk = gq[k*4+j] | (pp[k*4+j] & gk);
        pk = pk & pp[k*4+j];
      end
      s1_d.gp[k] = pk;
      s1_d.gg[k] = gk;
    end
  end

  always_comb begin
    cg    = '0;
    cg[0] = s1_q.c;
    for (int k = 0; k < NG; k++) begin
      cg[k+1] = s1_q.gg[k] | (s1_q.gp[k] & cg[k]);
    end
    hs = '0;
    cr = 1'b0;
    for (int i = 0; i < HW; i++) begin
      if (i % 4 == 0) cr = cg[i/4];
      hs[i] = s1_q.p[i] ^ cr;
      cr = s1_q.g[i] | (s1_q.p[i] & cr);
    end
    s2_d = {cg[NG], hs, s1_q.lo};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) s1_q <= s1_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_q <= s2_d;
    end
  end

endmodule

// File: tb/tb_heaa_32b9inacc_sub_pipe.sv
// Bench for the pipelined HEAA approximate subtractor.
// Directed table, reset, capacity, streaming and throughput checks.
module tb_heaa_32b9inacc_sub_pipe;

  localparam int W  = 32;
  localparam int IN = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  heaa_32b9inacc_sub_pipe_if #(.WIDTH(W)) bus ();

  heaa_32b9inacc_sub_pipe #(.WIDTH(W), .INACC(IN)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   exp;
  } vec_t;

  int total = 0;
  int bad = 0;
  int n_out = 0;
  logic [W:0] expq[$];
  logic prev_stall = 1'b0;
  logic [W:0] prev_diff = '0;
  logic seen_full = 1'b0;

  task automatic check(input string nm, input logic [W:0] act,
                       input logic [W:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [W:0] ref_sub(input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W-1:0] nb;
    logic [W:0]   r;
    logic [W:0]   hi;
    logic         c;
    nb = ~b;
    r  = '0;
    for (int i = 0; i < IN - 1; i++) r[i] = a[i] | nb[i];
    r[IN-1] = a[IN-1] ^ nb[IN-1];
    c = a[IN-1] & nb[IN-1];
    hi = ({1'b0, a} >> IN) + ({1'b0, nb} >> IN) + {{W{1'b0}}, c};
    r = r | (hi << IN);
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", {32'd0, bus.out_valid}, 33'd1);
        check("hold_diff", bus.diff, prev_diff);
      end
      if (bus.in_valid && !bus.in_ready) seen_full = 1'b1;
      if (bus.in_valid && bus.in_ready)
        expq.push_back(ref_sub(bus.a, bus.b));
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out: got %h want none", bus.diff);
        end else begin
          check("stream", bus.diff, expq.pop_front());
          n_out++;
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_diff  = bus.diff;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[4];
    logic fire;
    logic [W-1:0] pa;
    logic [W-1:0] pb;
    int n_sent;
    int cyc;
    int base;
    int acc;

    vt[0] = '{32'h0000_1000, 32'h0000_0001, 33'h1_0000_0FFE};
    vt[1] = '{32'h0000_0000, 32'h0000_0000, 33'h0_FFFF_FFFF};
    vt[2] = '{32'h8000_0000, 32'h0000_0000, 33'h1_7FFF_FFFF};
    vt[3] = '{32'h0000_0A00, 32'h0000_0200, 33'h1_0000_07FF};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_out_valid", {32'd0, bus.out_valid}, 33'd0);
    check("rst_diff", bus.diff, 33'd0);
    check("rst_in_ready", {32'd0, bus.in_ready}, 33'd1);

    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      bus.a = vt[i].a;
      bus.b = vt[i].b;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("vec_valid", {32'd0, bus.out_valid}, 33'd1);
      check("vec_diff", bus.diff, vt[i].exp);
    end

    // reset with both stages full and the output stalled
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a = $urandom;
    bus.b = $urandom;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {32'd0, bus.out_valid}, 33'd0);
    check("midrst_diff", bus.diff, 33'd0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rel_out_valid", {32'd0, bus.out_valid}, 33'd0);
    check("rel_diff", bus.diff, 33'd0);
    check("rel_in_ready", {32'd0, bus.in_ready}, 33'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale", {32'd0, bus.out_valid}, 33'd0);
    end

    // capacity: stalled output, empty pipe admits exactly two pairs
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.a = $urandom;
      bus.b = $urandom;
      @(negedge clk);
      fire = bus.in_ready;
      @(posedge clk);
      #1;
      if (fire) acc++;
    end
    check("capacity", 33'(acc), 33'd2);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("cap_drained", 33'(expq.size()), 33'd0);

    // random stream with a stall on cycles 5-9
    seen_full = 1'b0;
    base = n_out;
    n_sent = 0;
    cyc = 0;
    pa = $urandom;
    pb = $urandom;
    while (n_sent < 100 && cyc < 1000) begin
      bus.out_ready = !(cyc >= 5 && cyc <= 9);
      bus.in_valid = 1'b1;
      bus.a = pa;
      bus.b = pb;
      @(negedge clk);
      fire = bus.in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (fire) begin
        n_sent++;
        pa = $urandom;
        pb = $urandom;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cyc = 0;
    while ((n_out - base < 100 || expq.size() != 0) && cyc < 50) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    check("stream_sent", 33'(n_sent), 33'd100);
    check("stream_count", 33'(n_out - base), 33'd100);
    check("stream_left", 33'(expq.size()), 33'd0);
    check("in_ready_fell", {32'd0, seen_full}, 33'd1);

    // back-to-back throughput
    @(posedge clk);
    #1;
    for (int c = 0; c < 22; c++) begin
      if (c < 20) begin
        bus.in_valid = 1'b1;
        bus.a = $urandom;
        bus.b = $urandom;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 20) check("b2b_in_ready", {32'd0, bus.in_ready}, 33'd1);
      if (c >= 2) check("b2b_out_valid", {32'd0, bus.out_valid}, 33'd1);
      else check("b2b_lat", {32'd0, bus.out_valid}, 33'd0);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("b2b_left", 33'(expq.size()), 33'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/heaa_32b9inacc_sub_pipe.md
# heaa_32b9inacc_sub_pipe

Pipelined approximate subtractor built on the HEAA 32-bit / 9-inaccurate-bit scheme. It computes `a - b` as `a + ~b` with the same low-part approximation as the adder: OR-approximated low bits, a half-add boundary bit and an exact carry-lookahead high part. It sits on a valid/ready stream between operand producers and the accuracy-evaluation datapath. Two register stages give one result per cycle under a full handshake.

## Interface
- `WIDTH`, 32: operand width; result is `WIDTH+1` bits.
- `INACC`, 9: number of inaccurate low bits; legal range is 1 to `WIDTH-1`.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: operand pair `a`/`b` is valid.
- `in_ready`, output, 1: block accepts the operand pair this cycle.
- `a`, input, `WIDTH`: minuend.
- `b`, input, `WIDTH`: subtrahend.
- `out_valid`, output, 1: `diff` is valid.
- `out_ready`, input, 1: consumer accepts `diff`.
- `diff`, output, `WIDTH+1`: approximate difference. `diff[WIDTH]` is the carry-out, where 1 means no borrow.

## Operation
- **Operand transform.** `nb = ~b`. There is no +1 carry-in; it is absorbed by the approximation.
- **Bits 0 to `INACC-2`.** `diff[i] = a[i] | nb[i]`. No carry is produced.
- **Bit `INACC-1`.** `diff = a ^ nb` and `c = a & nb`. `c` is the only carry into the exact part.
- **Bits `INACC` to `WIDTH-1`.** Exact sum of `a[WIDTH-1:INACC] + nb[WIDTH-1:INACC] + c`, computed as a 4-bit-group carry-lookahead. A leading partial group takes the remainder width. The carry-out goes to `diff[WIDTH]`.
- **Stage 1 register** holds:
  - the finished low `INACC` bits of `diff`;
  - per-bit p/g of the high part;
  - the per-group lookahead terms (`P`, `G` per group);
  - `c`.
- **Stage 2 register** holds the result of the inter-group carry chain plus the sum XORs, i.e. the full `diff`.
- **Handshake.**
  - A transfer occurs when valid and ready are both high.
  - Stage 2 advances when it is empty or `out_ready` is high. Stage 1 advances when stage 2 advances or stage 1 is empty.
  - `in_ready = !s1_valid | s2_advance`. This is combinational from `out_ready` and is never a function of `in_valid`.
- **Reset.** Clears both stage-valid flags and the data registers. After reset:
  - `out_valid = 0`;
  - `diff = 0`;
  - `in_ready = 1`.

  A reset mid-stream discards in-flight data with no partial output.
- **Data holding.** `diff` and `out_valid` hold stable while `out_valid` is high and `out_ready` is low. Data is never dropped or duplicated.

## Timing
- Latency: 2 cycles. A pair accepted at edge N appears on `diff` with `out_valid` high after edge N+2 when there is no backpressure.
- Throughput: 1 result per cycle with `in_valid` and `out_ready` held high.
- Capacity: 2 entries. With `out_ready` low, `in_ready` stays high until both stages are full, then drops in the same cycle stage 1 fills.
- Simultaneous events:
  - When output is consumed and new input is accepted in the same cycle with both stages full, both stages shift and `in_ready` stays high.
  - An output stall while stage 1 is empty still lets one new pair enter.
- Critical path per stage: at most one XOR/AND plus the group lookahead (stage 1), and the group carry ripple plus XOR (stage 2).

## Test plan
- **Reset values:** assert `rst_n=0` mid-stream, then release. Required: `out_valid=0`, `diff=0`, `in_ready=1` immediately after release; no stale output afterwards.
- **Borrow-free case:** `a=0x00001000`, `b=0x00000001`. Required: `diff=0x1_00000FFE` two cycles later (the exact result would be 0xFFF).
- **Zero operands:** `a=0`, `b=0`. Required: `diff=0x0_FFFFFFFF`, i.e. carry-out 0 and all low bits set.
- **Large minuend:** `a=0x80000000`, `b=0`. Required: `diff=0x1_7FFFFFFF`.
  - Follow-up with `a=0x00000A00`, `b=0x00000200`. Required: `diff=0x1_000007FF`.
- **Streaming and backpressure:** stream 100 random pairs with `in_valid=1` and hold `out_ready=0` for cycles 5–9. Required:
  - `in_ready` falls once 2 entries are held;
  - results arrive in order and match the reference model;
  - no loss or duplication;
  - `diff` is stable while stalled.
- **Back-to-back throughput:** with `out_ready=1`, apply pairs on consecutive cycles. Required: `out_valid` high every cycle from cycle 2 onward and one result per cycle.
